vec_mem_sequencer: RTL and testbench
====================================

Name: vec_mem_sequencer

Overview:
- Sequences element-by-element transfers between the 256-bit vector register path and the 16-bit-wide data RAM.
- Also handles single-element scalar accesses.
- Sits in the MEM stage, between the EX/MEM segment register and the RAM. It drives the RAM address, data and write-enable.
- Holds the pipeline stalled while a transfer is in flight, and hands a gathered vector plus destination register to MEM/WB.

Parameters:
- ELEMENTS, 16, elements per vector register.
- ELEM_W, 16, bits per element and per RAM word.
- ADDR_W, 19, RAM address width; matches scalar register width.
- MEM_LAT, 1, RAM read latency in clk cycles (1..3).
- CNT_W, 19, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM-stage memory operation present.
- req_write  in  1  1 = store, 0 = load.
- req_vector  in  1  1 = ELEMENTS-element access, 0 = single element.
- base_addr  in  ADDR_W  start address (scalar ALU result).
- wdata_vec  in  ELEMENTS*ELEM_W  store data; element i is bits [i*ELEM_W +: ELEM_W].
- wdata_scalar  in  ELEM_W  scalar store data.
- rd_in  in  5  destination register of a load.
- mem_rdata  in  ELEM_W  RAM q.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  ELEM_W  RAM data.
- mem_wren  out  1  RAM write enable.
- stall  out  1  freeze IF/ID/EX and the EX/MEM register.
- done  out  1  one-cycle pulse; transfer complete.
- rdata_vec  out  ELEMENTS*ELEM_W  gathered load data.
- rd_out  out  5  captured destination register.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.
- cnt_clr  in  1  synchronous clear of stall_cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - mem_addr=0, mem_wdata=0, mem_wren=0.
  - done=0, rdata_vec=0, rd_out=0.
  - stall_cycles=0, internal index=0.
  - stall=0 while rst is high.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - A request is accepted when req_valid=1.
  - On acceptance, capture base_addr, wdata (vector or scalar), rd_in, req_write and count (ELEMENTS if req_vector, else 1). Clear idx.
  - Next state is WRITE if req_write, else READ.
- WRITE:
  - Each cycle: mem_addr=base+idx, mem_wdata=element idx (scalar: captured wdata_scalar), mem_wren=1, idx++.
  - After the cycle with idx=count-1, go to DONE.
- READ:
  - Each cycle: mem_addr=base+idx, mem_wren=0, idx++.
  - Push the tag {valid, idx} into a MEM_LAT-deep shift register.
  - When the tag emerges, write mem_rdata into buffer slot idx.
  - After the last issue, go to DRAIN.
- DRAIN:
  - Stay until the tag shift register is empty (MEM_LAT cycles), then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - rdata_vec and rd_out are valid from this cycle and held until the next load's DONE.
  - Scalar load: element 0 = data, elements 1..ELEMENTS-1 = 0.
  - Store: rdata_vec and rd_out are unchanged.
- Addressing: base+idx is computed modulo 2^ADDR_W (wraps at the top address, no error).
- stall is combinational: (state==IDLE && req_valid) || state in {WRITE, READ, DRAIN}. stall=0 in DONE so the pipeline advances in the same cycle it consumes done.
- req_valid outside IDLE is ignored. The requester holds it because it is stalled, and the held request is not re-accepted in DONE.
- Buffer clear: the buffer is cleared at acceptance of each load.
- Latency:
  - Vector store: done at cycle ELEMENTS+1 after the accept cycle.
  - Vector load: done at cycle ELEMENTS+MEM_LAT+1.
  - Scalar: 2 and 2+MEM_LAT respectively.
- Reset mid-operation: the transfer is aborted immediately. mem_wren drops asynchronously, no done pulse occurs, and the partial buffer is cleared.
- stall_cycles: increments on every cycle with stall=1 and saturates at 2^CNT_W-1. cnt_clr has priority over increment.

Decomposition:
- Package vmem_pkg holds:
  - state enum vmem_state_t (IDLE, WRITE, READ, DRAIN, DONE);
  - constants ELEMENTS, ELEM_W, ADDR_W;
  - typedef elem_vec_t = logic [ELEMENTS-1:0][ELEM_W-1:0].
- One sub-module, vmem_read_gather: the MEM_LAT tag shift register plus the element buffer, with a clear and an empty flag.

Test Plan:
- Vector store, base=0x00010, element i=0x0100+i, MEM_LAT=1 -> mem_wren high 16 cycles, addr 0x10..0x1F, data 0x0100..0x010F; done at cycle 17; stall high cycles 0..16.
- Vector load, base=0x00020, RAM model holds 0xA000+addr, rd_in=7 -> done at cycle 18, rdata_vec element i = 0xA020+i, rd_out=7; the same test with MEM_LAT=3 gives done at cycle 20.
- Scalar store 0x1234 at 0x00005, then scalar load at 0x00005 -> one wren cycle; load done 3 cycles after accept, element 0 = 0x1234, others 0.
- Wrap: vector store base=0x7FFF8 -> addresses 0x7FFF8..0x7FFFF, then 0x00000..0x00007.
- rst asserted at cycle 5 of a vector load -> same-cycle return to IDLE, stall=0, no done, rdata_vec=0; a following load completes normally.
- Counter: preload stall_cycles to 2^19-2 via a long sequence, or force it -> saturates at 0x7FFFF; cnt_clr together with stall gives 0.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory sequencer: element geometry, address width,
// FSM state encoding and the wrapping element-address helper.
package vmem_pkg;

  localparam int unsigned ELEMENTS = 16;
  localparam int unsigned ELEM_W   = 16;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned SLOT_W   = $clog2(ELEMENTS);
  // One extra bit so a full-vector count of ELEMENTS is representable.
  localparam int unsigned IDX_W    = SLOT_W + 1;

  typedef logic [ELEMENTS-1:0][ELEM_W-1:0] elem_vec_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } vmem_state_t;

  // Address of element idx; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/vmem_read_gather.sv
// Tracks in-flight RAM reads with a MemLat-deep tag pipe and scatters returning words into the
// element buffer at the slot carried by each tag.
module vmem_read_gather
  import vmem_pkg::*;
#(
  parameter int unsigned MemLat = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [SLOT_W-1:0] push_idx_i,
  input  logic [ELEM_W-1:0] rdata_i,
  output elem_vec_t         buf_o,
  output logic              empty_o
);

  logic [MemLat-1:0]             tag_valid_q, tag_valid_d;
  logic [MemLat-1:0][SLOT_W-1:0] tag_idx_q, tag_idx_d;
  elem_vec_t                     buf_q, buf_d;

  always_comb begin
    tag_valid_d[0] = push_i;
    tag_idx_d[0]   = push_idx_i;
    for (int i = 1; i < int'(MemLat); i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_idx_d[i]   = tag_idx_q[i-1];
    end

    buf_d = buf_q;
    if (tag_valid_q[MemLat-1]) begin
      buf_d[tag_idx_q[MemLat-1]] = rdata_i;
    end

    if (clear_i) begin
      tag_valid_d = '0;
      buf_d       = '0;
    end

    // Empty once the oldest tag retires this cycle: only the final stage may still be valid.
    empty_o = 1'b1;
    for (int i = 0; i < int'(MemLat) - 1; i++) begin
      if (tag_valid_q[i]) empty_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_valid_q <= '0;
      tag_idx_q   <= '0;
      buf_q       <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_idx_q   <= tag_idx_d;
      buf_q       <= buf_d;
    end
  end

  assign buf_o = buf_q;

endmodule

// File: rtl/vec_mem_sequencer.sv
// MEM-stage sequencer: walks vector/scalar loads and stores one element per cycle over the 16-bit
// RAM, stalls the pipeline while busy and presents gathered load data to MEM/WB.
module vec_mem_sequencer
  import vmem_pkg::*;
#(
  parameter int unsigned MemLat = 1,
  parameter int unsigned CntW   = 19
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  input  logic                       req_write_i,
  input  logic                       req_vector_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [ELEMENTS*ELEM_W-1:0] wdata_vec_i,
  input  logic [ELEM_W-1:0]          wdata_scalar_i,
  input  logic [4:0]                 rd_in_i,
  input  logic [ELEM_W-1:0]          mem_rdata_i,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [ELEM_W-1:0]          mem_wdata_o,
  output logic                       mem_wren_o,
  output logic                       stall_o,
  output logic                       done_o,
  output logic [ELEMENTS*ELEM_W-1:0] rdata_vec_o,
  output logic [4:0]                 rd_out_o,
  output logic [CntW-1:0]            stall_cycles_o,
  input  logic                       cnt_clr_i
);

  localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IdxFull = IDX_W'(ELEMENTS);

  vmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  elem_vec_t         wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  count_q, count_d;
  elem_vec_t         rdata_q;
  logic [4:0]        rd_out_q;
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;

  logic      last_elem;
  logic      gather_push;
  logic      gather_clear;
  logic      gather_empty;
  elem_vec_t gather_buf;
  elem_vec_t rdata_vec;
  logic [4:0] rd_out;

  vmem_read_gather #(
    .MemLat(MemLat)
  ) u_gather (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (gather_clear),
    .push_i    (gather_push),
    .push_idx_i(idx_q[SLOT_W-1:0]),
    .rdata_i   (mem_rdata_i),
    .buf_o     (gather_buf),
    .empty_o   (gather_empty)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    write_d      = write_q;
    idx_d        = idx_q;
    count_d      = count_q;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_wren_o   = 1'b0;
    done_o       = 1'b0;
    gather_push  = 1'b0;
    gather_clear = 1'b0;
    last_elem    = (idx_q == count_q - IdxOne);

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          base_d  = base_addr_i;
          rd_d    = rd_in_i;
          write_d = req_write_i;
          idx_d   = '0;
          count_d = req_vector_i ? IdxFull : IdxOne;
          if (req_vector_i) begin
            wdata_d = wdata_vec_i;
          end else begin
            wdata_d    = '0;
            wdata_d[0] = wdata_scalar_i;
          end
          gather_clear = !req_write_i;
          state_d      = req_write_i ? StWrite : StRead;
        end
      end
      StWrite: begin
        mem_addr_o  = elem_addr(base_q, idx_q);
        mem_wdata_o = wdata_q[idx_q[SLOT_W-1:0]];
        mem_wren_o  = 1'b1;
        idx_d       = idx_q + IdxOne;
        if (last_elem) state_d = StDone;
      end
      StRead: begin
        mem_addr_o  = elem_addr(base_q, idx_q);
        gather_push = 1'b1;
        idx_d       = idx_q + IdxOne;
        if (last_elem) state_d = StDrain;
      end
      StDrain: begin
        if (gather_empty) state_d = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Load results appear in the DONE cycle straight from the buffer, then are held in rdata_q.
  always_comb begin
    if (state_q == StDone && !write_q) begin
      rdata_vec = gather_buf;
      rd_out    = rd_q;
    end else begin
      rdata_vec = rdata_q;
      rd_out    = rd_out_q;
    end
  end

  assign rdata_vec_o = rdata_vec;
  assign rd_out_o    = rd_out;

  assign stall_o = !rst_i && ((state_q == StIdle && req_valid_i) || state_q == StWrite ||
                              state_q == StRead || state_q == StDrain);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if (stall_o && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CntW'(1);
    end
  end

  assign stall_cycles_o = stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      base_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      rd_out_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      rdata_q     <= rdata_vec;
      rd_out_q    <= rd_out;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench: three sequencers (read latency 1, read latency 3, 4-bit stall counter) share
// stimulus; each scenario task checks timing, RAM traffic, gathered data and the counter.
module tb_vec_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, req_valid, req_write, req_vector, cnt_clr;
  logic [18:0]  base_addr;
  logic [255:0] wdata_vec;
  logic [15:0]  wdata_scalar;
  logic [4:0]   rd_in;
  logic [15:0]  q1, q3, p3a, p3b;

  logic [18:0]  addr_a, addr_b, addr_c;
  logic [15:0]  wd_a, wd_b, wd_c;
  logic         wren_a, wren_b, wren_c, stall_a, stall_b, stall_c, done_a, done_b, done_c;
  logic [255:0] rv_a, rv_b, rv_c;
  logic [4:0]   rdo_a, rdo_b, rdo_c;
  logic [18:0]  sc_a, sc_b;
  logic [3:0]   sc_c;

  vec_mem_sequencer #(.MemLat(1), .CntW(19)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_vector_i(req_vector), .base_addr_i(base_addr), .wdata_vec_i(wdata_vec),
    .wdata_scalar_i(wdata_scalar), .rd_in_i(rd_in), .mem_rdata_i(q1), .mem_addr_o(addr_a),
    .mem_wdata_o(wd_a), .mem_wren_o(wren_a), .stall_o(stall_a), .done_o(done_a),
    .rdata_vec_o(rv_a), .rd_out_o(rdo_a), .stall_cycles_o(sc_a), .cnt_clr_i(cnt_clr)
  );

  vec_mem_sequencer #(.MemLat(3), .CntW(19)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_vector_i(req_vector), .base_addr_i(base_addr), .wdata_vec_i(wdata_vec),
    .wdata_scalar_i(wdata_scalar), .rd_in_i(rd_in), .mem_rdata_i(q3), .mem_addr_o(addr_b),
    .mem_wdata_o(wd_b), .mem_wren_o(wren_b), .stall_o(stall_b), .done_o(done_b),
    .rdata_vec_o(rv_b), .rd_out_o(rdo_b), .stall_cycles_o(sc_b), .cnt_clr_i(cnt_clr)
  );

  // Same latency as dut_a and identical stimulus, so it can share dut_a's RAM read port.
  vec_mem_sequencer #(.MemLat(1), .CntW(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_vector_i(req_vector), .base_addr_i(base_addr), .wdata_vec_i(wdata_vec),
    .wdata_scalar_i(wdata_scalar), .rd_in_i(rd_in), .mem_rdata_i(q1), .mem_addr_o(addr_c),
    .mem_wdata_o(wd_c), .mem_wren_o(wren_c), .stall_o(stall_c), .done_o(done_c),
    .rdata_vec_o(rv_c), .rd_out_o(rdo_c), .stall_cycles_o(sc_c), .cnt_clr_i(cnt_clr)
  );

  // RAM models: unwritten words read as 0xA000 + address.
  bit [15:0] ram1 [0:524287];
  bit        wr1  [0:524287];
  bit [15:0] ram3 [0:524287];
  bit        wr3  [0:524287];

  function automatic logic [15:0] rd1(input logic [18:0] a);
    return wr1[a] ? ram1[a] : 16'hA000 + a[15:0];
  endfunction

  function automatic logic [15:0] rd3(input logic [18:0] a);
    return wr3[a] ? ram3[a] : 16'hA000 + a[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (wren_a) begin
      ram1[addr_a] <= wd_a;
      wr1[addr_a]  <= 1'b1;
    end
    if (wren_b) begin
      ram3[addr_b] <= wd_b;
      wr3[addr_b]  <= 1'b1;
    end
    q1  <= rd1(addr_a);
    p3a <= rd3(addr_b);
    p3b <= p3a;
    q3  <= p3b;
  end

  int n_checks = 0;
  int n_pass   = 0;

  int          done1, done3, dones1, wren_n;
  logic [18:0] wa_log [0:39];
  logic [15:0] wd_log [0:39];
  bit          stall_log [0:39];

  // Presents one request and records dut_a traffic for ncyc cycles; cycle 0 is the accept cycle.
  task automatic run_op(input logic wr, input logic vec, input logic [18:0] base,
                        input logic [4:0] rd, input int ncyc);
    done1  = -1;
    done3  = -1;
    dones1 = 0;
    wren_n = 0;
    for (int i = 0; i < 40; i++) begin
      wa_log[i]    = '0;
      wd_log[i]    = '0;
      stall_log[i] = 1'b0;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_vector = vec;
    base_addr  = base;
    rd_in      = rd;
    for (int k = 0; k < ncyc; k++) begin
      #1;
      if (done_a) begin
        dones1++;
        if (done1 < 0) done1 = k;
      end
      if (done_b && done3 < 0) done3 = k;
      if (wren_a && wren_n < 40) begin
        wa_log[wren_n] = addr_a;
        wd_log[wren_n] = wd_a;
        wren_n++;
      end
      if (k < 40) stall_log[k] = stall_a;
      @(negedge clk);
      if (done1 >= 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (stall_a !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall_a);
    else n_pass++;
    n_checks++;
    if ({wren_a, done_a, addr_a, wd_a} !== '0)
      $display("FAIL reset_mem_if: got wren=%0b done=%0b addr=%0h data=%0h want all 0",
               wren_a, done_a, addr_a, wd_a);
    else n_pass++;
    n_checks++;
    if ({rv_a, rdo_a, sc_a} !== '0)
      $display("FAIL reset_outputs: got rdata=%0h rd=%0h cnt=%0h want 0", rv_a, rdo_a, sc_a);
    else n_pass++;
    n_checks++;
    if ({wren_b, wren_c, stall_b, stall_c, done_b, done_c} !== '0)
      $display("FAIL reset_other_ctrl: got %0b want 0",
               {wren_b, wren_c, stall_b, stall_c, done_b, done_c});
    else n_pass++;
    n_checks++;
    if ({addr_c, wd_c, rv_c, rdo_c, sc_b, sc_c, rv_b, rdo_b} !== '0)
      $display("FAIL reset_other_data: got nonzero want 0");
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector_store();
    int aerr, derr, serr;
    bit exp_s;
    for (int i = 0; i < 16; i++) wdata_vec[i*16 +: 16] = 16'h0100 + 16'(i);
    run_op(1'b1, 1'b1, 19'h00010, 5'd0, 24);
    aerr = 0;
    derr = 0;
    serr = 0;
    for (int i = 0; i < 16; i++) begin
      if (wa_log[i] !== 19'h00010 + 19'(i)) aerr++;
      if (wd_log[i] !== 16'h0100 + 16'(i)) derr++;
    end
    for (int k = 0; k < 24; k++) begin
      exp_s = (k <= 16);
      if (stall_log[k] !== exp_s) serr++;
    end
    n_checks++;
    if (done1 !== 17) $display("FAIL vst_done_cycle: got %0d want 17", done1);
    else n_pass++;
    n_checks++;
    if (dones1 !== 1) $display("FAIL vst_done_pulses: got %0d want 1", dones1);
    else n_pass++;
    n_checks++;
    if (wren_n !== 16) $display("FAIL vst_wren_cycles: got %0d want 16", wren_n);
    else n_pass++;
    n_checks++;
    if (aerr !== 0) $display("FAIL vst_addr: got %0d bad addresses want 0", aerr);
    else n_pass++;
    n_checks++;
    if (derr !== 0) $display("FAIL vst_data: got %0d bad words want 0", derr);
    else n_pass++;
    n_checks++;
    if (serr !== 0) $display("FAIL vst_stall: got %0d wrong stall cycles want 0", serr);
    else n_pass++;
    n_checks++;
    if ({rv_a, rdo_a} !== '0) $display("FAIL vst_rdata_kept: got %0h want 0", rv_a);
    else n_pass++;
    n_checks++;
    if (done3 !== 17) $display("FAIL vst_done_lat3: got %0d want 17", done3);
    else n_pass++;
    n_checks++;
    if (sc_a !== 19'd17) $display("FAIL vst_stall_count: got %0d want 17", sc_a);
    else n_pass++;
    n_checks++;
    if (sc_c !== 4'hF) $display("FAIL cnt_saturate: got %0d want 15", sc_c);
    else n_pass++;
  endtask

  task automatic test_vector_load(input logic [18:0] base, input logic [4:0] rd,
                                  input logic [18:0] exp_cnt);
    logic [255:0] exp_v;
    for (int i = 0; i < 16; i++) exp_v[i*16 +: 16] = 16'hA000 + base[15:0] + 16'(i);
    run_op(1'b0, 1'b1, base, rd, 26);
    n_checks++;
    if (done1 !== 18) $display("FAIL vld_done_lat1: got %0d want 18", done1);
    else n_pass++;
    n_checks++;
    if (done3 !== 20) $display("FAIL vld_done_lat3: got %0d want 20", done3);
    else n_pass++;
    n_checks++;
    if (wren_n !== 0) $display("FAIL vld_no_wren: got %0d want 0", wren_n);
    else n_pass++;
    n_checks++;
    if (rv_a !== exp_v) $display("FAIL vld_data_lat1: got %0h want %0h", rv_a, exp_v);
    else n_pass++;
    n_checks++;
    if (rv_b !== exp_v) $display("FAIL vld_data_lat3: got %0h want %0h", rv_b, exp_v);
    else n_pass++;
    n_checks++;
    if ({rdo_a, rdo_b, rdo_c} !== {rd, rd, rd})
      $display("FAIL vld_rd_out: got %0h/%0h/%0h want %0h", rdo_a, rdo_b, rdo_c, rd);
    else n_pass++;
    n_checks++;
    if (rv_c !== exp_v) $display("FAIL vld_data_c: got %0h want %0h", rv_c, exp_v);
    else n_pass++;
    n_checks++;
    if (sc_a !== exp_cnt) $display("FAIL vld_stall_count: got %0d want %0d", sc_a, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_scalar();
    wdata_scalar = 16'h1234;
    run_op(1'b1, 1'b0, 19'h00005, 5'd0, 8);
    n_checks++;
    if (wren_n !== 1) $display("FAIL sst_wren_cycles: got %0d want 1", wren_n);
    else n_pass++;
    n_checks++;
    if ({wa_log[0], wd_log[0]} !== {19'h00005, 16'h1234})
      $display("FAIL sst_write: got addr=%0h data=%0h want 5/1234", wa_log[0], wd_log[0]);
    else n_pass++;
    n_checks++;
    if (done1 !== 2) $display("FAIL sst_done_cycle: got %0d want 2", done1);
    else n_pass++;
    run_op(1'b0, 1'b0, 19'h00005, 5'd3, 10);
    n_checks++;
    if (done1 !== 3) $display("FAIL sld_done_lat1: got %0d want 3", done1);
    else n_pass++;
    n_checks++;
    if (done3 !== 5) $display("FAIL sld_done_lat3: got %0d want 5", done3);
    else n_pass++;
    n_checks++;
    if (rv_a !== {240'h0, 16'h1234}) $display("FAIL sld_data_lat1: got %0h want 1234", rv_a);
    else n_pass++;
    n_checks++;
    if (rv_b !== {240'h0, 16'h1234}) $display("FAIL sld_data_lat3: got %0h want 1234", rv_b);
    else n_pass++;
    n_checks++;
    if (rdo_a !== 5'd3) $display("FAIL sld_rd_out: got %0d want 3", rdo_a);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int aerr, derr;
    for (int i = 0; i < 16; i++) wdata_vec[i*16 +: 16] = 16'h0200 + 16'(i);
    run_op(1'b1, 1'b1, 19'h7FFF8, 5'd0, 24);
    aerr = 0;
    derr = 0;
    for (int i = 0; i < 16; i++) begin
      if (wa_log[i] !== 19'h7FFF8 + 19'(i)) aerr++;
      if (wd_log[i] !== 16'h0200 + 16'(i)) derr++;
    end
    n_checks++;
    if (wa_log[8] !== 19'h00000) $display("FAIL wrap_first_low: got %0h want 0", wa_log[8]);
    else n_pass++;
    n_checks++;
    if (aerr !== 0) $display("FAIL wrap_addr: got %0d bad addresses want 0", aerr);
    else n_pass++;
    n_checks++;
    if (derr !== 0 || wren_n !== 16)
      $display("FAIL wrap_data: got %0d bad words, %0d writes want 0, 16", derr, wren_n);
    else n_pass++;
  endtask

  task automatic test_counter();
    n_checks++;
    if (sc_a !== 19'd57) $display("FAIL cnt_accum: got %0d want 57", sc_a);
    else n_pass++;
    cnt_clr      = 1'b1;
    wdata_scalar = 16'h5555;
    run_op(1'b1, 1'b0, 19'h00030, 5'd0, 6);
    n_checks++;
    if ({sc_a, sc_c} !== '0) $display("FAIL cnt_clr_priority: got %0d/%0d want 0", sc_a, sc_c);
    else n_pass++;
    cnt_clr = 1'b0;
    run_op(1'b1, 1'b0, 19'h00031, 5'd0, 6);
    n_checks++;
    if (sc_a !== 19'd2 || sc_c !== 4'd2)
      $display("FAIL cnt_restart: got %0d/%0d want 2", sc_a, sc_c);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dn;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_vector = 1'b1;
    base_addr  = 19'h00040;
    rd_in      = 5'd9;
    for (int k = 0; k < 5; k++) begin
      #1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({stall_a, stall_b, wren_a, done_a} !== 4'b0)
      $display("FAIL rstmid_ctrl: got %0b want 0", {stall_a, stall_b, wren_a, done_a});
    else n_pass++;
    n_checks++;
    if ({rv_a, rdo_a} !== '0) $display("FAIL rstmid_rdata: got %0h rd=%0d want 0", rv_a, rdo_a);
    else n_pass++;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    dn = 0;
    for (int k = 0; k < 25; k++) begin
      #1;
      if (done_a || done_b || done_c) dn++;
      @(negedge clk);
    end
    n_checks++;
    if (dn !== 0 || rv_b !== '0) $display("FAIL rstmid_no_done: got %0d pulses want 0", dn);
    else n_pass++;
    test_vector_load(19'h00020, 5'd4, 19'd18);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_vector   = 1'b0;
    cnt_clr      = 1'b0;
    base_addr    = '0;
    wdata_vec    = '0;
    wdata_scalar = '0;
    rd_in        = '0;
    test_reset();
    test_vector_store();
    test_vector_load(19'h00020, 5'd7, 19'd35);
    test_scalar();
    test_wrap();
    test_counter();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
